// File: rtl/game_state_controller.sv
// Stickman runner game sequencer: cover/start gating, coin scoring, win/lose
// decision and frame-timed end-screen hold.
module game_state_controller #(
  parameter logic [7:0] START_KEY       = 8'h2C,
  parameter int         WIN_COINS       = 10,
  parameter int         END_HOLD_FRAMES = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       coin_hit,
  input  logic       stickman_dead,
  output logic [3:0] status,
  output logic [7:0] score,
  output logic       game_reset,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    PREWAIT = 3'd0,
    WAIT    = 3'd1,
    PLAY    = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } state_t;

  localparam logic [8:0] WIN_CNT  = 9'(WIN_COINS);
  localparam logic [9:0] HOLD_CNT = 10'(END_HOLD_FRAMES);

  state_t     state, state_n;
  logic [7:0] score_n;
  logic [9:0] hold_cnt, hold_n;
  logic [3:0] status_n;
  logic       game_reset_n;
  logic       fs1, fs2, fs3;
  logic       coin_q, coin_evt;

  assign coin_evt = coin_hit & ~coin_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs1        <= 1'b0;
      fs2        <= 1'b0;
      fs3        <= 1'b0;
      frame_tick <= 1'b0;
      coin_q     <= 1'b0;
      state      <= PREWAIT;
      status     <= 4'b1000;
      score      <= 8'd0;
      hold_cnt   <= 10'd0;
      game_reset <= 1'b0;
    end else begin
      // fs1/fs2 synchronize; fs3 is the history bit for the edge detect
      fs1        <= frame_clk;
      fs2        <= fs1;
      fs3        <= fs2;
      frame_tick <= fs2 & ~fs3;
      coin_q     <= coin_hit;
      state      <= state_n;
      status     <= status_n;
      score      <= score_n;
      hold_cnt   <= hold_n;
      game_reset <= game_reset_n;
    end
  end

  always_comb begin
    state_n      = state;
    score_n      = score;
    hold_n       = hold_cnt;
    game_reset_n = 1'b0;
    case (state)
      // A start key still held from the last game must be released first
      PREWAIT: if (keycode != START_KEY) state_n = WAIT;
      WAIT: begin
        if (keycode == START_KEY) begin
          state_n      = PLAY;
          score_n      = 8'd0;
          game_reset_n = 1'b1;
        end
      end
      PLAY: begin
        if (stickman_dead) begin
          state_n = LOSE;
          hold_n  = 10'd0;
        end else if (coin_evt) begin
          score_n = (score == 8'hFF) ? 8'hFF : score + 8'd1;
          if ({1'b0, score} + 9'd1 == WIN_CNT) begin
            state_n = WIN;
            hold_n  = 10'd0;
          end
        end
      end
      WIN, LOSE: begin
        if (frame_tick) begin
          hold_n = hold_cnt + 10'd1;
          if (hold_cnt + 10'd1 == HOLD_CNT) state_n = PREWAIT;
        end
      end
      default: state_n = PREWAIT;
    endcase

    case (state_n)
      PLAY:    status_n = 4'b0100;
      WIN:     status_n = 4'b0010;
      LOSE:    status_n = 4'b0001;
      default: status_n = 4'b1000;
    endcase
  end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level game sequencer for the stickman runner.
- Produces the one-hot game status {waiting, playing, win, lose} that drives the color mapper.
- Counts collected coins and decides win/lose from collision inputs.
- Times the end-screen hold in frames, then returns to the cover screen.

Parameters:
START_KEY, 8'h2C, USB keycode that starts a game (space).
WIN_COINS, 10, coin count that ends play with a win (1..255).
END_HOLD_FRAMES, 180, number of frame ticks the win/lose screen is held (1..1023).

Ports:
Clk  input  1  system clock (50 MHz)
Reset  input  1  synchronous, active-high reset
frame_clk  input  1  VGA vertical sync; asynchronous to Clk logic, synchronized internally
keycode  input  8  current keyboard keycode; 0 means no key pressed
coin_hit  input  1  level from coin collision logic; each rising edge counts as one coin
stickman_dead  input  1  level; stickman fell or collided
status  output  4  one-hot {waiting, playing, win, lose}
score  output  8  coins collected in the current or most recent game
game_reset  output  1  one-Clk pulse that re-initializes stickman, ground and coin modules
frame_tick  output  1  one-Clk pulse per frame_clk rising edge

Behaviour:
- Reset is synchronous and active-high, with one clock. When Reset is high at a Clk edge:
  - state goes to PREWAIT and status = 4'b1000.
  - score = 0, game_reset = 0, frame_tick = 0, hold counter = 0.
  - frame_clk synchronizer flops and the coin edge register are cleared.
- Reset asserted mid-game behaves identically from any state.
- frame_clk input path:
  - 2-flop synchronizer, then a registered rising-edge detect.
  - frame_tick goes high 3 Clk after the edge reaches the first flop, for exactly 1 Clk.
- coin_hit input path:
  - registered once; a coin event is a rising edge (coin_hit = 1 while the previous sample = 0).
  - a level held high counts once.
- States and status encoding:
  - PREWAIT -> 1000
  - WAIT -> 1000
  - PLAY -> 0100
  - WIN -> 0010
  - LOSE -> 0001
  - status is registered and changes on the same edge as the state.
- PREWAIT:
  - when keycode != START_KEY -> WAIT.
  - guards against a start key still held from the previous game.
- WAIT:
  - when keycode == START_KEY -> PLAY.
  - on that same edge: score <= 0 and game_reset <= 1 for exactly one Clk.
- PLAY:
  - transitions are evaluated every Clk, not only on frame ticks.
  - priority 1: stickman_dead = 1 -> LOSE. A coin event in the same cycle is discarded; score is unchanged.
  - priority 2: on a coin event, score <= score + 1, saturating at 255.
  - if score + 1 == WIN_COINS -> WIN on the same edge; score shows the final count.
  - keycode is ignored in PLAY.
- WIN / LOSE:
  - the hold counter (10-bit) clears on entry and increments on each frame_tick.
  - when the counter reaches END_HOLD_FRAMES (the tick that makes the count equal) -> PREWAIT.
  - score holds its value until the next entry to PLAY.
  - coin_hit, stickman_dead and keycode are ignored.
- game_reset is asserted only on the WAIT->PLAY edge; it is never asserted by Reset itself.
- There are no illegal reachable states. Any unused encoding goes to PREWAIT on the next Clk.

Test Plan:
1. Reset start-up: assert Reset 2 cycles with keycode = 8'h2C held, then release Reset and keep 8'h2C for 10 cycles -> status stays 1000 (PREWAIT, no start). Drop keycode to 0, then press 8'h2C -> status becomes 0100 and game_reset is high for exactly 1 Clk on that edge.
2. Win path (WIN_COINS = 3, END_HOLD_FRAMES = 4): in PLAY, give 3 coin_hit pulses, one of them held high 20 cycles -> score increments 1, 2, 3 (held pulse counted once). On the 3rd edge, status = 0010. After 4 frame_clk edges, status = 1000 and score stays 3.
3. Lose with simultaneous coin: in PLAY with score = 1, raise coin_hit and stickman_dead in the same cycle -> status = 0001, score stays 1. Next start clears score to 0.
4. Frame tick latency: toggle frame_clk at an arbitrary phase -> frame_tick pulses once per rising edge, 3 Clk after sampling, width 1 Clk. Falling edges produce nothing.
5. Mid-game reset: in PLAY with score = 2, assert Reset for 1 cycle -> next Clk status = 1000, score = 0, game_reset = 0. In LOSE with hold count 2, assert Reset -> PREWAIT and the hold counter is cleared.
6. Saturation (WIN_COINS = 255 minus override, e.g. a bench parameter of 255): apply 300 coin events -> score reaches 255 and enters WIN exactly at 255, never wrapping to 0.
